// File: rtl/ble_cfg_sequencer_pkg.sv
// Shared constants for the BLE/BT module configuration sequencer:
// ASCII codes, FSM state encoding and the AT command strings.
package ble_cfg_sequencer_pkg;

  localparam int CMD_MAX_LEN  = 9;   // longest command including CR LF
  localparam int HM10_CMD_CNT = 7;
  localparam int HC05_CMD_CNT = 6;

  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  // One command line, byte 0 is the first character sent. Unused tail
  // bytes are zero and never reached because LF ends the line.
  typedef logic [0:CMD_MAX_LEN-1][7:0] cmd_str_t;

  // Eight slots per table so any 3-bit index is in range; spare slots are zero.
  localparam logic [0:7][CMD_MAX_LEN*8-1:0] HM10_CMDS = {
    {"AT",      ASCII_CR, ASCII_LF, 40'h0},
    {"AT+NAME", ASCII_CR, ASCII_LF},
    {"AT+PIN",  ASCII_CR, ASCII_LF, 8'h0},
    {"AT+ROLE", ASCII_CR, ASCII_LF},
    {"AT+IMME", ASCII_CR, ASCII_LF},
    {"AT+BAUD", ASCII_CR, ASCII_LF},
    {"AT+MODE", ASCII_CR, ASCII_LF},
    72'h0
  };

  localparam logic [0:7][CMD_MAX_LEN*8-1:0] HC05_CMDS = {
    {"AT",      ASCII_CR, ASCII_LF, 40'h0},
    {"AT+NAME", ASCII_CR, ASCII_LF},
    {"AT+PSWD", ASCII_CR, ASCII_LF},
    {"AT+ROLE", ASCII_CR, ASCII_LF},
    {"AT+UART", ASCII_CR, ASCII_LF},
    {"AT+ADDR", ASCII_CR, ASCII_LF},
    72'h0,
    72'h0
  };

  function automatic int cmd_count(input int module_sel);
    return (module_sel == 1) ? HC05_CMD_CNT : HM10_CMD_CNT;
  endfunction

endpackage

// File: rtl/ble_cmd_rom.sv
// Combinational AT command ROM: returns the byte at (cmd_idx, byte_idx)
// for the selected module and flags the line terminator.
module ble_cmd_rom
  import ble_cfg_sequencer_pkg::*;
#(
  parameter int MODULE_SEL = 0
) (
  input  logic [2:0] cmd_idx,
  input  logic [3:0] byte_idx,
  output logic [7:0] cmd_byte,
  output logic       last
);

  cmd_str_t line;

  // Select the command line, then the byte; LF marks the end of a command.
  always_comb begin
    line     = (MODULE_SEL == 1) ? HC05_CMDS[cmd_idx] : HM10_CMDS[cmd_idx];
    cmd_byte = 8'h00;
    if (byte_idx < 4'(CMD_MAX_LEN))
      cmd_byte = line[byte_idx];
    last = (cmd_byte == ASCII_LF);
  end

endmodule

// File: rtl/ble_cfg_sequencer.sv
// Power-up configuration sequencer for an HM-10 / HC-05 module: streams
// each AT command to the UART TX, waits for "OK" with timeout and retry,
// and reports done or error.
module ble_cfg_sequencer
  import ble_cfg_sequencer_pkg::*;
#(
  parameter int MODULE_SEL       = 0,
  parameter int RESP_TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRIES      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_cmd
);

  localparam int CMD_CNT = cmd_count(MODULE_SEL);
  localparam int TW      = $clog2(RESP_TIMEOUT_CYC);
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [2:0]    CMD_LAST  = 3'(CMD_CNT - 1);

  state_t          state, state_nxt;
  logic [2:0]      cmd_idx;
  logic [3:0]      byte_idx;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            prev_o;

  logic [7:0]      rom_byte;
  logic            rom_last;
  logic            tx_fire, rx_match, tmo_hit, retry_ok, last_cmd, idle_like;

  ble_cmd_rom #(.MODULE_SEL(MODULE_SEL)) u_rom (
    .cmd_idx  (cmd_idx),
    .byte_idx (byte_idx),
    .cmd_byte (rom_byte),
    .last     (rom_last)
  );

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign tx_fire   = (state == ST_SEND) && tx_ready;
  assign rx_match  = (state == ST_WAIT_RESP) && rx_valid && (rx_data == ASCII_K) && prev_o;
  assign tmo_hit   = (state == ST_WAIT_RESP) && (tmo_cnt == TMO_LAST);
  assign retry_ok  = (retry_cnt < RETRY_MAX);
  assign last_cmd  = (cmd_idx == CMD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a match beats a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (start) state_nxt = ST_SEND;
      ST_SEND:
        if (tx_fire && rom_last) state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP:
        if (rx_match)     state_nxt = ST_NEXT;
        else if (tmo_hit) state_nxt = retry_ok ? ST_SEND : ST_ERROR;
      ST_NEXT:
        state_nxt = last_cmd ? ST_DONE : ST_SEND;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; tx_data follows the registered indices so it holds through stalls.
  always_comb begin
    tx_valid = (state == ST_SEND);
    tx_data  = (state == ST_SEND) ? rom_byte : 8'h00;
    busy     = !idle_like;
    done     = (state == ST_DONE);
    error    = (state == ST_ERROR);
  end

  // Command/byte indices, retry and timeout counters, "OK" matcher, err_cmd.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_idx   <= '0;
      byte_idx  <= '0;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      prev_o    <= 1'b0;
      err_cmd   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            cmd_idx   <= '0;
            byte_idx  <= '0;
            retry_cnt <= '0;
            err_cmd   <= '0;
          end
        end
        ST_SEND: begin
          if (tx_fire) begin
            if (rom_last) begin
              tmo_cnt <= '0;
              prev_o  <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        ST_WAIT_RESP: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (rx_valid)
            prev_o <= (rx_data == ASCII_O);
          if (!rx_match && tmo_hit) begin
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RW'(1);
              byte_idx  <= '0;
            end else begin
              err_cmd <= cmd_idx;
            end
          end
        end
        ST_NEXT: begin
          retry_cnt <= '0;
          byte_idx  <= '0;
          if (!last_cmd) cmd_idx <= cmd_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ble_cfg_sequencer.md
Name: ble_cfg_sequencer

Overview:
- Configures an attached BLE/BT module (HM-10 or HC-05) after power-up by walking the shared AT command set byte by byte.
- Sits between the board-level controller and the UART TX/RX datapath.
- Streams each command to the UART TX, then waits for an "OK" reply, with timeout and bounded retry.
- Reports done or error to the system controller.

Parameters:
- MODULE_SEL, 0, command set select: 0 = HM-10 (7 commands), 1 = HC-05 (6 commands).
- RESP_TIMEOUT_CYC, 1000000, clock cycles allowed from the last TX byte to a complete "OK"; must be at least 2.
- MAX_RETRIES, 2, re-sends allowed per command before error; 0 = no retry.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins the sequence from IDLE, DONE or ERROR.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts the byte; transfer happens on a cycle where tx_valid && tx_ready.
- rx_data  in  8  byte from UART RX.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- busy  out  1  sequence in progress.
- done  out  1  level; high after all commands acknowledged, cleared by start or rst.
- error  out  1  level; high after retries exhausted, cleared by start or rst.
- err_cmd  out  3  index of the failing command; valid while error = 1.

Behaviour:
- Reset state: IDLE; tx_valid, busy, done, error = 0; tx_data = 0; err_cmd = 0; all counters = 0.
- States: IDLE, SEND, WAIT_RESP, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR with start = 1: cmd_idx = 0, byte_idx = 0, retry_cnt = 0, clear done/error, go to SEND. busy = 1 in every state except IDLE, DONE and ERROR.
- start in any other state is ignored.
- SEND:
  - tx_valid = 1 and tx_data = ROM byte at (cmd_idx, byte_idx), presented combinationally from registered indices.
  - tx_data must stay stable while tx_valid && !tx_ready.
  - On transfer: if the byte is last (LF), go to WAIT_RESP with timeout counter = 0 and match state cleared; otherwise byte_idx++.
  - Under continuous tx_ready, one byte is sent per cycle.
- WAIT_RESP:
  - tx_valid = 0; the timeout counter increments every cycle.
  - The matcher tracks "prev byte = 'O'". An rx byte 'K' (0x4B) with prev 'O' (0x4F) means acknowledged: go to NEXT.
  - Any other byte updates prev. CR and LF are treated as ordinary non-matching bytes.
  - Counter reaching RESP_TIMEOUT_CYC-1 without a match:
    - if retry_cnt < MAX_RETRIES: retry_cnt++, byte_idx = 0, go to SEND;
    - else: err_cmd = cmd_idx, go to ERROR.
  - A match and a timeout in the same cycle: the match wins.
- NEXT (1 cycle): retry_cnt = 0, byte_idx = 0.
  - If cmd_idx is the last command: go to DONE.
  - Else: cmd_idx++, go to SEND.
- rx bytes arriving outside WAIT_RESP are discarded. The matcher is cleared on entry to WAIT_RESP.
- DONE: done = 1. ERROR: error = 1. Both states hold until start or rst.
- rst in any state, including mid-byte with tx_valid high, returns to the reset state next cycle. The UART may see a truncated command; that is acceptable, because the module tolerates an aborted line.
- Minimum latency from start to first tx_valid: 1 cycle.

Decomposition:
- Shared package (extend the command-memory package):
  - command count per module;
  - max command length (9 bytes incl. CR LF);
  - ASCII constants 'O', 'K', CR, LF;
  - state enum typedef.
- Sub-module ble_cmd_rom, combinational:
  - inputs: MODULE_SEL, cmd_idx[2:0], byte_idx[3:0];
  - outputs: byte[7:0], last;
  - contents derived from the package command strings, so the sequencer never touches strings.

Test Plan:
- HM-10 full run, tx_ready tied high, responder returns "OK\r\n" 20 cycles after each LF.
  -> 7 commands sent in order; first bytes are 0x41 0x54 0x0D 0x0A; done = 1; error = 0; 7 WAIT_RESP entries.
- tx_ready toggling 1-of-3 cycles.
  -> tx_data stable while stalled; byte stream identical to the first test; no byte duplicated or dropped.
- Command 2 (PIN) unanswered once, RESP_TIMEOUT_CYC = 50, MAX_RETRIES = 2.
  -> "AT+PIN\r\n" resent exactly once after 50 cycles; the sequence then completes with done = 1.
- No responder at all.
  -> command 0 sent 3 times; then error = 1, err_cmd = 0, busy = 0.
- Responder sends "XOOK".
  -> acknowledged. Responder sends "O\nK".
  -> not acknowledged, so timeout.
- rst asserted mid-command 3 with tx_valid high, then start.
  -> all outputs at reset values the next cycle; restart begins at command 0, byte 0.
- start pulsed during WAIT_RESP.
  -> ignored; the sequence continues unchanged.
